mult_result_buffer: RTL and testbench
=====================================

// Module: mult_result_buffer
// PURPOSE
//  Downstream stage of radix4_mult. Captures each 64-bit product on the multiplier's valid_out/C.
//  Presents products in order on a ready/valid output. radix4_mult cannot stall, so the block
//  also tracks in-flight operations and grants upstream issue credit (issue_ok). This guarantees
//  every launched product has a reserved slot before it is issued.
// PARAMETERS
//  DATA_W   64   product width; must match radix4_mult C width
//  DEPTH    8    result slots; power of two, >= 2
//  CNT_W    $clog2(DEPTH+1)   localparam, width of occupancy/in-flight counters
// PORTS
//  CLK          in   1       single clock, all state on posedge
//  rst          in   1       synchronous, active-high reset
//  issue_in     in   1       upstream launches an operand pair (same cycle it drives radix4_mult valid_in)
//  issue_ok     out  1       credit available: upstream may assert issue_in this cycle
//  valid_in     in   1       radix4_mult valid_out
//  C            in   DATA_W  radix4_mult product
//  out_valid    out  1       head product available
//  out_ready    in   1       consumer accepts head; transfer = out_valid & out_ready
//  out_data     out  DATA_W  head product
//  count        out  CNT_W   products stored
//  inflight     out  CNT_W   issued, not yet returned
//  err_overflow out  1       sticky: issue without credit, or push with no free slot
//  err_unexp    out  1       sticky: valid_in while inflight==0
// BEHAVIOUR
//  Reset (rst=1 at posedge): wr_ptr, rd_ptr, count, inflight = 0; err_* = 0.
//   Outputs then read out_valid=0, issue_ok=1, out_data=mem[0] (don't-care, not reset).
//  issue_ok = (count + inflight) < DEPTH. Combinational from registers only.
//   A same-cycle pop does not raise it (conservative).
//  inflight update: +issue_in - (valid_in & inflight!=0); both in the same cycle -> unchanged.
//  push = valid_in & (inflight!=0). Write C to mem[wr_ptr]; wr_ptr+1, wrapping mod DEPTH.
//  pop  = out_valid & out_ready. rd_ptr+1 mod DEPTH.
//   count: +push -pop; simultaneous push and pop -> unchanged.
//  out_valid = (count != 0). out_data = mem[rd_ptr], asynchronous read.
//   Latency: product captured at edge N is visible at out_data after edge N; pop possible at edge N+1.
//  Ordering: strict FIFO; products leave in issue order.
//  Full (count==DEPTH): push with same-cycle pop is accepted.
//   Push without pop: the write is dropped, state is unchanged, err_overflow<=1.
//   With correct credit use this cannot occur.
//  Empty: out_valid=0; out_ready is ignored; rd_ptr holds.
//  issue_in while issue_ok==0: still counted (inflight saturates at DEPTH); err_overflow<=1.
//  valid_in while inflight==0: product discarded, err_unexp<=1.
//   This covers stale results arriving after a mid-operation reset of this block only.
//  Reset mid-operation: all stored and in-flight tracking is lost; the consumer sees out_valid drop next cycle.
//  Error flags clear only on rst.
//  Arithmetic: pointers are $clog2(DEPTH) bits with natural wrap; counters are CNT_W bits, never wrap.
// STRUCTURE
//  Package mult_pkg: DATA_W localparam = 64; typedef logic [DATA_W-1:0] product_t.
//   Shared with radix4_mult and its testbenches.
//  Sub-module result_fifo_ram: DEPTH x DATA_W storage.
//   One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
//  Top level holds pointers, counters, credit and error logic.
// TESTING (tb_mult_result_buffer, CLK period 10, rst high 4 cycles)
//  1. Reset: after rst -> out_valid=0, issue_ok=1, count=0, inflight=0, err_*=0.
//  2. Single op: issue_in 1 cycle, 3 cycles later valid_in with C=10000 (100*100), out_ready=1
//     -> out_data=10000 and out_valid high for exactly 1 cycle; inflight 1->0.
//  3. Fill: 8 issues with out_ready=0 -> issue_ok falls after 8th; return products 1..8
//     -> count=8; then out_ready=1 drains 1..8 in order; err_overflow=0.
//  4. Full + simultaneous: count=7, inflight=1, valid_in(C=42) with pop same cycle
//     -> count stays 7; 42 emerges last; no error.
//  5. Violations: issue_in with issue_ok=0 -> err_overflow=1, inflight saturates at 8;
//     valid_in with inflight=0 -> err_unexp=1, count unchanged.
//  6. Mid-op reset: 3 stored, 2 in flight, assert rst -> count=0, out_valid=0;
//     late valid_in (C=7) -> discarded, err_unexp=1.
//  Pointer wrap: run 20 back-to-back ops with random out_ready; scoreboard checks ordering.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for radix4_mult and its downstream result buffer.
package mult_pkg;

    localparam int DATA_W = 64;

    typedef logic [DATA_W-1:0] product_t;

    typedef struct packed {
        logic overflow;
        logic unexp;
    } err_t;

endpackage

// File: rtl/result_fifo_ram.sv
// Result storage: one synchronous write port, one asynchronous read port.
module result_fifo_ram #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mult_result_buffer.sv
// In-order product buffer behind radix4_mult with issue credit tracking,
// so every launched operation already owns a slot when it returns.
module mult_result_buffer #(
    parameter int DATA_W = mult_pkg::DATA_W,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              issue_in,
    output logic              issue_ok,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] C,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  inflight,
    output logic              err_overflow,
    output logic              err_unexp
);

    import mult_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    err_t             err_q, err_d;

    logic             ret;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             drop;
    logic [CNT_W:0]   occ;

    // Credit looks only at registered state; a same-cycle pop is not counted.
    assign occ      = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ok = occ < (CNT_W + 1)'(DEPTH);

    always_comb begin
        ret     = valid_in && (inflight_q != '0);
        pop     = (count_q != '0) && out_ready;
        full    = (count_q == CNT_W'(DEPTH));
        push_ok = ret && (!full || pop);
        drop    = ret && full && !pop;

        inflight_d = inflight_q;
        if (issue_in && !ret) begin
            if (inflight_q != CNT_W'(DEPTH)) begin
                inflight_d = inflight_q + CNT_W'(1);
            end
        end else if (!issue_in && ret) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        err_d.overflow = err_q.overflow
                       | (issue_in & ~issue_ok)
                       | drop;
        err_d.unexp    = err_q.unexp
                       | (valid_in & (inflight_q == '0));
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    result_fifo_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (CLK),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (C),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign out_valid    = (count_q != '0);
    assign count        = count_q;
    assign inflight     = inflight_q;
    assign err_overflow = err_q.overflow;
    assign err_unexp    = err_q.unexp;

endmodule

// File: tb/tb_mult_result_buffer.sv
// Scoreboard bench for mult_result_buffer: credit, ordering, errors, reset.
module tb_mult_result_buffer;

    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK;
    logic          rst;
    logic          issue_in;
    logic          issue_ok;
    logic          valid_in;
    logic [DW-1:0] C;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          err_overflow;
    logic          err_unexp;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    logic [DW-1:0] sb[$];

    mult_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .rst          (rst),
        .issue_in     (issue_in),
        .issue_ok     (issue_ok),
        .valid_in     (valid_in),
        .C            (C),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .inflight     (inflight),
        .err_overflow (err_overflow),
        .err_unexp    (err_unexp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            issue_in = 1'b1;
            tick();
        end
        issue_in = 1'b0;
    endtask

    task automatic ret_prod(input logic [DW-1:0] p, input bit expect_keep);
        valid_in = 1'b1;
        C        = p;
        if (expect_keep) sb.push_back(p);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (count == '0) break;
            tick();
        end
        out_ready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_sb_left", sb.size(), 0);
    endtask

    // Outputs are checked on the falling edge, before the popping rising edge.
    always @(negedge CLK) begin
        if (!rst && out_valid && out_ready) begin
            n_pop++;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_data", out_data, sb.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic          pv [3];
    logic [DW-1:0] pd [3];
    logic [DW-1:0] prod;
    int            n_iss;
    int            pop_base;
    bit            done;
    bit            iss;

    initial begin
        issue_in  = 1'b0;
        valid_in  = 1'b0;
        C         = '0;
        out_ready = 1'b0;
        do_reset();

        chk("rst_out_valid", out_valid, 0);
        chk("rst_issue_ok", issue_ok, 1);
        chk("rst_count", count, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err_ovf", err_overflow, 0);
        chk("rst_err_unexp", err_unexp, 0);

        // single operation, 3-cycle return
        out_ready = 1'b1;
        issue_n(1);
        chk("single_inflight1", inflight, 1);
        tick();
        tick();
        ret_prod(64'd10000, 1'b1);
        chk("single_inflight0", inflight, 0);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 64'd10000);
        tick();
        chk("single_valid_1cyc", out_valid, 0);
        out_ready = 1'b0;

        // fill to capacity through credit
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_issue_ok", issue_ok, 1);
            issue_n(1);
        end
        chk("fill_issue_ok_low", issue_ok, 0);
        chk("fill_inflight", inflight, DEPTH);
        for (int i = 1; i <= DEPTH; i++) ret_prod(DW'(i), 1'b1);
        chk("fill_count", count, DEPTH);
        chk("fill_inflight0", inflight, 0);
        chk("fill_issue_ok_full", issue_ok, 0);
        drain(40);
        chk("fill_err_ovf", err_overflow, 0);

        // push and pop in the same cycle at count 7
        issue_n(DEPTH);
        for (int i = 101; i <= 107; i++) ret_prod(DW'(i), 1'b1);
        chk("simul_count7", count, 7);
        chk("simul_inflight1", inflight, 1);
        out_ready = 1'b1;
        ret_prod(64'd42, 1'b1);
        out_ready = 1'b0;
        chk("simul_count_hold", count, 7);
        chk("simul_inflight0", inflight, 0);
        drain(40);
        chk("simul_err_ovf", err_overflow, 0);
        chk("simul_err_unexp", err_unexp, 0);

        // credit violation and unexpected return
        issue_n(DEPTH);
        chk("viol_issue_ok", issue_ok, 0);
        issue_n(1);
        chk("viol_err_ovf", err_overflow, 1);
        chk("viol_inflight_sat", inflight, DEPTH);
        for (int i = 201; i <= 208; i++) ret_prod(DW'(i), 1'b1);
        chk("viol_count", count, DEPTH);
        ret_prod(64'd999, 1'b0);
        chk("viol_err_unexp", err_unexp, 1);
        chk("viol_count_hold", count, DEPTH);
        drain(40);
        chk("viol_err_sticky", err_overflow, 1);
        do_reset();
        chk("clr_err_ovf", err_overflow, 0);
        chk("clr_err_unexp", err_unexp, 0);

        // reset in the middle of operation
        issue_n(5);
        for (int i = 301; i <= 303; i++) ret_prod(DW'(i), 1'b1);
        chk("mid_count3", count, 3);
        chk("mid_inflight2", inflight, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("mid_count0", count, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_inflight0", inflight, 0);
        ret_prod(64'd7, 1'b0);
        chk("mid_err_unexp", err_unexp, 1);
        chk("mid_count_hold", count, 0);
        chk("mid_out_valid2", out_valid, 0);
        do_reset();

        // back-to-back ops with random backpressure; pointers wrap
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        n_iss    = 0;
        done     = 1'b0;
        pop_base = n_pop;
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            valid_in  = pv[2];
            C         = pd[2];
            if (pv[2]) sb.push_back(pd[2]);
            iss      = (n_iss < 20) && issue_ok;
            issue_in = iss;
            prod     = DW'($urandom_range(1, 65535))
                     * DW'($urandom_range(1, 65535));
            pv[2] = pv[1];
            pd[2] = pd[1];
            pv[1] = pv[0];
            pd[1] = pd[0];
            pv[0] = iss;
            pd[0] = iss ? prod : '0;
            if (iss) n_iss++;
            tick();
            done = (n_iss == 20) && !pv[0] && !pv[1] && !pv[2]
                 && (count == '0) && !valid_in;
        end
        issue_in  = 1'b0;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        chk("wrap_done", done, 1);
        chk("wrap_pops", n_pop - pop_base, 20);
        chk("wrap_sb_left", sb.size(), 0);
        chk("wrap_err_ovf", err_overflow, 0);
        chk("wrap_err_unexp", err_unexp, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
